// File: rtl/block_packer_pkg.sv
// block_packer_pkg: shared constants for the sector block packer.
// Holds the 3-bit Gray-like state encodings (same family as the D-line
// driver) and the sector geometry constants.
`timescale 1ns/1ps
package block_packer_pkg;

  localparam int unsigned SECTOR_NIBBLES    = 1024;
  localparam int unsigned NIBBLES_PER_BLOCK = 16;

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_LOAD  = 3'b001;
  localparam logic [2:0] S_START = 3'b011;
  localparam logic [2:0] S_WAIT  = 3'b010;
  localparam logic [2:0] S_STORE = 3'b110;
  localparam logic [2:0] S_DONE  = 3'b111;

endpackage

// File: rtl/block_packer_if.sv
// block_packer_if: RAM, cipher and control signals of block_packer.
// Optional macro BLOCK_PACKER_BYPASS_EN adds the ibypass input.
`timescale 1ns/1ps
interface block_packer_if #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned BLOCK_W = 64
) ();

  logic               istart;
  logic [ADDR_W-1:0]  oraddr;
  logic [3:0]         irdata;
  logic [ADDR_W-1:0]  owaddr;
  logic [3:0]         owdata;
  logic               owrite_en;
  logic [BLOCK_W-1:0] oblock;
  logic               ostart_cipher;
  logic [BLOCK_W-1:0] iblock;
  logic               icipher_done;
  logic               odone;
`ifdef BLOCK_PACKER_BYPASS_EN
  logic               ibypass;

  modport slave (
    input  istart, irdata, iblock, icipher_done, ibypass,
    output oraddr, owaddr, owdata, owrite_en, oblock, ostart_cipher, odone
  );

  modport master (
    output istart, irdata, iblock, icipher_done, ibypass,
    input  oraddr, owaddr, owdata, owrite_en, oblock, ostart_cipher, odone
  );
`else
  modport slave (
    input  istart, irdata, iblock, icipher_done,
    output oraddr, owaddr, owdata, owrite_en, oblock, ostart_cipher, odone
  );

  modport master (
    output istart, irdata, iblock, icipher_done,
    input  oraddr, owaddr, owdata, owrite_en, oblock, ostart_cipher, odone
  );
`endif

endinterface

// File: rtl/block_packer.sv
// block_packer: reads a 1024-nibble sector from the receive RAM, packs it
// into 64-bit blocks (lowest address = most significant nibble), runs each
// block through the cipher and unpacks the result into the send RAM.
// Optional macro BLOCK_PACKER_BYPASS_EN: ibypass sampled on istart skips
// the cipher for the whole sector.
`timescale 1ns/1ps
module block_packer
  import block_packer_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned BLOCK_W  = 64,
  parameter int unsigned N_BLOCKS = 64
) (
  input logic           iclk,
  input logic           irst_n,
  block_packer_if.slave bus
);

  localparam int unsigned BI_W = ADDR_W - 4;

  logic [2:0]         state;
  logic [BI_W-1:0]    bi;
  logic [4:0]         c;
  logic [3:0]         k;
  logic [BLOCK_W-1:0] shreg;
  logic [BLOCK_W-1:0] rreg;
  logic [BLOCK_W-1:0] oblock_q;
  logic [ADDR_W-1:0]  waddr_hold;
  logic [3:0]         wdata_hold;
  logic               start_q;
  logic               done_q;
  logic               bypass_q;

  logic [BLOCK_W-1:0] shreg_next;
  logic               in_store;
  logic               last_blk;
  logic               load_end;
  logic               store_end;

  assign shreg_next = {shreg[BLOCK_W-5:0], bus.irdata};
  assign in_store   = (state == S_STORE);
  assign last_blk   = (bi == BI_W'(N_BLOCKS - 1));
  assign load_end   = (c == 5'(NIBBLES_PER_BLOCK));
  assign store_end  = (k == 4'(NIBBLES_PER_BLOCK - 1));

`ifdef BLOCK_PACKER_BYPASS_EN
  // Bypass mode is latched at sector start and held for the whole sector.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      bypass_q <= 1'b0;
    end else if (state == S_IDLE && bus.istart) begin
      bypass_q <= bus.ibypass;
    end
  end
`else
  assign bypass_q = 1'b0;
`endif

  // Sector sequencer: load, cipher handshake, store, completion pulse.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state      <= S_IDLE;
      bi         <= '0;
      c          <= '0;
      k          <= '0;
      shreg      <= '0;
      rreg       <= '0;
      oblock_q   <= '0;
      waddr_hold <= '0;
      wdata_hold <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.istart) begin
            bi    <= '0;
            c     <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // RAM data lags the address by one cycle, so capture starts at c=1
          if (c != 5'd0) begin
            shreg <= shreg_next;
          end
          if (load_end) begin
            c <= '0;
            if (bypass_q) begin
              rreg  <= shreg_next;
              k     <= '0;
              state <= S_STORE;
            end else begin
              oblock_q <= shreg_next;
              start_q  <= 1'b1;
              state    <= S_START;
            end
          end else begin
            c <= c + 5'd1;
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.icipher_done) begin
            rreg  <= bus.iblock;
            k     <= '0;
            state <= S_STORE;
          end
        end
        S_STORE: begin
          waddr_hold <= {bi, k};
          wdata_hold <= rreg[BLOCK_W-1 -: 4];
          rreg       <= {rreg[BLOCK_W-5:0], 4'h0};
          k          <= k + 4'd1;
          if (store_end) begin
            if (last_blk) begin
              state <= S_DONE;
            end else begin
              bi    <= bi + BI_W'(1);
              c     <= '0;
              state <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          // odone is registered, so its pulse lands in the cycle after DONE
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.oraddr        = {bi, c[3:0]};
  assign bus.owrite_en     = in_store;
  assign bus.owaddr        = in_store ? {bi, k} : waddr_hold;
  assign bus.owdata        = in_store ? rreg[BLOCK_W-1 -: 4] : wdata_hold;
  assign bus.oblock        = oblock_q;
  assign bus.ostart_cipher = start_q;
  assign bus.odone         = done_q;

endmodule

// File: tb/tb_block_packer.sv
// tb_block_packer: table-driven sector runs with a write scoreboard, a
// parameterised cipher stub, and hand sequences for spurious strobes,
// mid-operation reset and (with BLOCK_PACKER_BYPASS_EN) bypass mode.
`timescale 1ns/1ps
module tb_block_packer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  block_packer_if bus ();

  block_packer dut (
    .iclk   (clk),
    .irst_n (rst_n),
    .bus    (bus)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [3:0] rmem [0:1023];
  logic [3:0] smem [0:1023];

  typedef struct packed {
    logic [9:0] a;
    logic [3:0] d;
  } wr_t;
  wr_t sbq [$];

  typedef struct {
    int          pat;
    logic [63:0] mask;
    int          lat;
    logic [63:0] blk0;
    int          cycles;
  } vec_t;

  // cipher stub state
  logic [63:0] mask   = '0;
  int          lat    = 1;
  logic        busy   = 1'b0;
  int          cnt    = 0;
  logic [63:0] held   = '0;
  logic        inj    = 1'b0;
  logic        inj_en = 1'b0;
  int          gap    = 0;

  // monitor state
  int          n_starts  = 0;
  int          n_done    = 0;
  int          done_cyc  = 0;
  logic [63:0] blk0      = '0;
  logic        blk0_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_nib(input int a, input logic byp);
    int sh;
    sh = (15 - (a % 16)) * 4;
    if (byp) return rmem[a];
    return rmem[a] ^ 4'(mask >> sh);
  endfunction

  task automatic fill(input int pat);
    for (int n = 0; n < 1024; n++) begin
      case (pat)
        0:       rmem[n] = 4'(n);
        1:       rmem[n] = 4'h0;
        default: rmem[n] = 4'((n * 7 + 3) % 16);
      endcase
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // receive RAM with one-cycle read latency; send RAM capture
  always @(posedge clk) begin
    bus.irdata <= rmem[bus.oraddr];
    if (bus.owrite_en) smem[bus.owaddr] <= bus.owdata;
  end

  // cipher stub plus spurious-strobe injector
  always @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else if (bus.ostart_cipher) begin
      busy <= 1'b1;
      cnt  <= lat - 1;
      held <= bus.oblock ^ mask;
    end else if (busy && cnt == 0) begin
      busy <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - 1;
    end
    gap <= bus.owrite_en ? 0 : ((gap < 1000) ? gap + 1 : gap);
    inj <= inj_en && ((bus.owrite_en && bus.owaddr[3:0] == 4'd7) || gap == 5);
  end

  assign bus.icipher_done = (busy && cnt == 0) || inj;
  assign bus.iblock       = (busy && cnt == 0) ? held : 64'hDEAD_BEEF_CAFE_F00D;

  // output monitor: scoreboard pops on writes, pulse counting
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.owrite_en) begin
        if (sbq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                   bus.owaddr, bus.owdata);
        end else begin
          wr_t e;
          e = sbq.pop_front();
          check("write", 64'({bus.owaddr, bus.owdata}), 64'({e.a, e.d}));
        end
      end
      if (bus.ostart_cipher) begin
        if (!blk0_seen) begin
          blk0      = bus.oblock;
          blk0_seen = 1'b1;
        end
        n_starts++;
      end
      if (bus.odone) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic load_scoreboard(input logic byp);
    sbq.delete();
    for (int a = 0; a < 1024; a++) sbq.push_back({10'(a), exp_nib(a, byp)});
    n_starts  = 0;
    n_done    = 0;
    blk0      = '0;
    blk0_seen = 1'b0;
  endtask

  task automatic pulse_start(input logic byp, output int t0);
    @(negedge clk);
`ifdef BLOCK_PACKER_BYPASS_EN
    bus.ibypass = byp;
`endif
    bus.istart = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.istart = 1'b0;
`ifdef BLOCK_PACKER_BYPASS_EN
    bus.ibypass = ~byp;
`endif
    check("oraddr_first", 64'(bus.oraddr), 64'd0);
  endtask

  task automatic run_sector(input logic byp, input int exp_starts, input int exp_cycles,
                            input logic [63:0] exp_blk0, input logic mid_start);
    int t0;
    int bad;
    load_scoreboard(byp);
    pulse_start(byp, t0);
    for (int i = 0; i < 6000 && n_done == 0; i++) begin
      @(negedge clk);
      bus.istart = (mid_start && i == 500);
    end
    bus.istart = 1'b0;
    check("done_seen", 64'(n_done), 64'd1);
    check("done_latency", 64'(done_cyc - t0), 64'(exp_cycles));
    @(negedge clk);
    check("done_width", 64'({bus.odone, bus.owrite_en}), 64'd0);
    repeat (4) @(negedge clk);
    check("done_count", 64'(n_done), 64'd1);
    check("writes_left", 64'(sbq.size()), 64'd0);
    check("start_count", 64'(n_starts), 64'(exp_starts));
    check("block0", blk0, exp_blk0);
    bad = 0;
    for (int a = 0; a < 1024; a++) if (smem[a] !== exp_nib(a, byp)) bad++;
    check("sram_image", 64'(bad), 64'd0);
  endtask

  vec_t tbl [3];

  initial begin
    int t0;
    logic found;

    tbl[0] = '{pat: 0, mask: 64'h0, lat: 1,
               blk0: 64'h0123456789ABCDEF, cycles: 64 * 35 + 2};
    tbl[1] = '{pat: 1, mask: 64'hFFFF_FFFF_FFFF_FFFF, lat: 5,
               blk0: 64'h0, cycles: 64 * 39 + 2};
    tbl[2] = '{pat: 2, mask: 64'h0F1E_2D3C_4B5A_6978, lat: 3,
               blk0: 64'h3A18F6D4B2907E5C, cycles: 64 * 37 + 2};

    bus.istart = 1'b0;
`ifdef BLOCK_PACKER_BYPASS_EN
    bus.ibypass = 1'b0;
`endif
    fill(0);
    for (int a = 0; a < 1024; a++) smem[a] = 4'hX;

    // reset state
    #2;
    check("rst_addr_data", 64'({bus.oraddr, bus.owaddr, bus.owdata}), 64'd0);
    check("rst_strobes", 64'({bus.owrite_en, bus.ostart_cipher, bus.odone}), 64'd0);
    check("rst_oblock", bus.oblock, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_strobes", 64'({bus.owrite_en, bus.ostart_cipher, bus.odone}), 64'd0);

    // table-driven sectors
    for (int v = 0; v < 3; v++) begin
      fill(tbl[v].pat);
      mask = tbl[v].mask;
      lat  = tbl[v].lat;
      run_sector(1'b0, 64, tbl[v].cycles, tbl[v].blk0, 1'b0);
    end

    // spurious icipher_done in LOAD/STORE and istart mid-sector
    fill(2);
    mask   = 64'h1234_5678_9ABC_DEF0;
    lat    = 2;
    inj_en = 1'b1;
    run_sector(1'b0, 64, 64 * 36 + 2, 64'h3A18F6D4B2907E5C, 1'b1);
    inj_en = 1'b0;

    // asynchronous reset during STORE of block 10
    fill(0);
    mask = 64'h0;
    lat  = 1;
    load_scoreboard(1'b0);
    pulse_start(1'b0, t0);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      found = bus.owrite_en && (bus.owaddr == 10'd163);
    end
    check("reach_blk10", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_addr_data", 64'({bus.oraddr, bus.owaddr, bus.owdata}), 64'd0);
    check("arst_strobes", 64'({bus.owrite_en, bus.ostart_cipher, bus.odone}), 64'd0);
    check("arst_oblock", bus.oblock, 64'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_sector(1'b0, 64, 64 * 35 + 2, 64'h0123456789ABCDEF, 1'b0);

`ifdef BLOCK_PACKER_BYPASS_EN
    // bypass: sector copied unchanged, cipher never started
    fill(2);
    mask = 64'hFFFF_FFFF_FFFF_FFFF;
    run_sector(1'b1, 0, 64 * 33 + 2, 64'h0, 1'b0);
    // bypass cleared again at next istart
    run_sector(1'b0, 64, 64 * 35 + 2, 64'h3A18F6D4B2907E5C, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
